// File: rtl/fp_mul_ci.sv
// rtl/fp_mul_ci.sv - Nios II multi-cycle custom-instruction front end for an external fp_mul pipeline
// Issues registered operands, waits LATENCY enabled cycles, captures q with an optional sign post-op.
module fp_mul_ci #(
  parameter int LATENCY = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      dataa,
  input  logic [31:0]      datab,
  input  logic [1:0]       n,
  output logic [31:0]      result,
  output logic             done,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_q,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LATENCY);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [1:0]  op_reg;
  logic [31:0] post_q;
  logic        issue;
  logic        capture;

  assign issue   = clk_en && (state == S_IDLE) && start;
  assign capture = clk_en && (state == S_WAIT) && (cnt == 4'd1);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= S_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sign post-op is applied blindly, zero and NaN included.
  always_comb begin
    post_q = mul_q;
    case (op_reg)
      2'd2:    post_q = {~mul_q[31], mul_q[30:0]};
      2'd3:    post_q = {1'b0, mul_q[30:0]};
      default: post_q = mul_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      result   <= '0;
      done     <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      op_count <= '0;
      cnt      <= '0;
      op_reg   <= '0;
    end else if (clk_en) begin
      done <= capture;
      if (issue) begin
        mul_a  <= dataa;
        mul_b  <= (n == 2'd1) ? dataa : datab;
        op_reg <= n;
        cnt    <= LAT_L;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        result   <= post_q;
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_ci.sv
// tb/tb_fp_mul_ci.sv - self-checking bench for fp_mul_ci with a behavioural fp_mul stand-in
module tb_fp_mul_ci;
  localparam int LAT   = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             areset, clk_en, start;
  logic [31:0]      dataa, datab, result, mul_a, mul_b, mul_q;
  logic [1:0]       n;
  logic             done, busy;
  logic [CNT_W-1:0] op_count;

  int total  = 0;
  int passed = 0;
  int exp_cnt = 0;

  fp_mul_ci #(.LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .areset(areset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .result(result), .done(done),
    .mul_a(mul_a), .mul_b(mul_b), .mul_q(mul_q), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal/zero operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else m = p[45:23];
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [31:0] q;
    q = fmul(a, (op == 2'd1) ? a : b);
    case (op)
      2'd2:    return {~q[31], q[30:0]};
      2'd3:    return {1'b0, q[30:0]};
      default: return q;
    endcase
  endfunction

  // fp_mul model: q sampled at the LATENCY-th edge after an operand change is valid.
  logic [31:0] pipe [0:LAT-2];
  always @(posedge clk) begin
    pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_q = pipe[LAT-2];

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, output int lat);
    dataa = a; datab = b; n = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dataa = $urandom; datab = $urandom; n = 2'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    if (lat > 0) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; clk_en = 1'b0; start = 1'b0; dataa = '0; datab = '0; n = '0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0; clk_en = 1'b1;
    exp_cnt = 0;
    total++; if (result !== 32'd0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if ({mul_a, mul_b} !== 64'd0) $display("FAIL reset_operands got=%h/%h exp=0/0", mul_a, mul_b); else passed++;
    total++; if (op_count !== '0) $display("FAIL reset_op_count got=%0d exp=0", op_count); else passed++;
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'hC0000000, 32'h00000000};
    logic [31:0] vb [5] = '{32'h40400000, 32'hDEADBEEF, 32'h40400000, 32'h40400000, 32'h40A00000};
    logic [1:0]  vn [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] vr [5] = '{32'h40C00000, 32'h41100000, 32'hC0C00000, 32'h40C00000, 32'h00000000};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vn[i], lat);
      total++; if (lat !== LAT) $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, LAT); else passed++;
      total++; if (result !== vr[i]) $display("FAIL dir_result[%0d] got=%h exp=%h", i, result, vr[i]); else passed++;
      total++; if (op_count !== CNT_W'(exp_cnt)) $display("FAIL dir_op_count[%0d] got=%0d exp=%0d", i, op_count, exp_cnt); else passed++;
    end
  endtask

  task automatic test_square_operand();
    dataa = 32'h40400000; datab = 32'hDEADBEEF; n = 2'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; dataa = 32'h12345678; datab = 32'h9ABCDEF0;
    total++; if (mul_b !== 32'h40400000) $display("FAIL square_mul_b got=%h exp=40400000", mul_b); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL square_busy got=%b exp=1", busy); else passed++;
    repeat (LAT + 1) @(posedge clk);
    #1 exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    total++; if (mul_a !== 32'h40400000) $display("FAIL square_mul_a_hold got=%h exp=40400000", mul_a); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL square_idle got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    dataa = 32'h40000000; datab = 32'h40400000; n = 2'd0; start = 1'b1;
    @(posedge clk); #1 dataa = 32'h3F800000;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 3) start = 1'b0;
      if (done) pulses++;
    end
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    total++; if (pulses !== 1) $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); else passed++;
    total++; if (result !== 32'h40C00000) $display("FAIL busy_ignore_result got=%h exp=40C00000", result); else passed++;
    total++; if (mul_a !== 32'h40000000) $display("FAIL busy_ignore_mul_a got=%h exp=40000000", mul_a); else passed++;
  endtask

  task automatic test_stall();
    int lat = -1;
    logic [31:0] prev;
    prev = result;
    dataa = 32'hC0000000; datab = 32'h40400000; n = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 2) clk_en = 1'b0;
      if (k == 5) clk_en = 1'b1;
      if (clk_en && done) begin lat = k; break; end
      if (k == 4 && result !== prev) begin
        total++; $display("FAIL stall_result_hold got=%h exp=%h", result, prev);
      end
    end
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    total++; if (lat !== LAT + 3) $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT + 3); else passed++;
    total++; if (result !== 32'h40C00000) $display("FAIL stall_result got=%h exp=40C00000", result); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int pulses = 0;
    int lat;
    dataa = 32'h40000000; datab = 32'h40400000; n = 2'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 areset = 1'b1;
    @(posedge clk); #1 areset = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL abort_no_done got=%0d exp=0", pulses); else passed++;
    total++; if (result !== 32'd0) $display("FAIL abort_result got=%h exp=0", result); else passed++;
    total++; if (op_count !== '0) $display("FAIL abort_op_count got=%0d exp=0", op_count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_idle got=%b exp=0", busy); else passed++;
    run_op(32'h40400000, 32'h40400000, 2'd0, lat);
    total++; if (lat !== LAT || result !== 32'h41100000) $display("FAIL abort_restart got=%0d/%h exp=%0d/41100000", lat, result, LAT); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    logic [1:0]  op;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      if (i % 7 == 3) a = {a[31], 31'd0};
      op = 2'($urandom);
      exp = ref_op(a, b, op);
      run_op(a, b, op, lat);
      total++; if (lat !== LAT || result !== exp) $display("FAIL rand[%0d] got=%0d/%h exp=%0d/%h", i, lat, result, LAT, exp); else passed++;
      total++; if (op_count !== CNT_W'(exp_cnt)) $display("FAIL rand_op_count[%0d] got=%0d exp=%0d", i, op_count, exp_cnt); else passed++;
    end
  endtask

  task automatic test_wrap();
    int lat;
    int guard = 0;
    while (exp_cnt != (1 << CNT_W) - 1 && guard < 40) begin
      run_op(32'h3F800000, 32'h40000000, 2'd0, lat);
      guard++;
    end
    total++; if (op_count !== '1) $display("FAIL wrap_all_ones got=%0d exp=%0d", op_count, (1 << CNT_W) - 1); else passed++;
    run_op(32'h3F800000, 32'h40000000, 2'd3, lat);
    total++; if (op_count !== '0) $display("FAIL wrap_zero got=%0d exp=0", op_count); else passed++;
    total++; if (result !== 32'h40000000) $display("FAIL wrap_result got=%h exp=40000000", result); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_square_operand();
    test_busy_ignore();
    test_stall();
    test_abort();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
